// File: rtl/present_decoder_if.sv
// Load/result bus shared by the PRESENT encoder and decoder blocks.
// The master drives the load strobes and the input bus; the slave returns status and the result.
interface present_decoder_if;
   logic [1:0]  pl;
   logic [79:0] in_text;
   logic        ready;
   logic        done;
   logic [63:0] plaintext;

   modport master (output pl, in_text, input ready, done, plaintext);
   modport slave  (input pl, in_text, output ready, done, plaintext);
endinterface

// File: rtl/present_decoder.sv
// Iterative PRESENT-80 decryptor, one inverse round per clock.
// K32 is cached once per key load, and round keys are rolled backwards from it.
module present_decoder #(
   parameter logic [79:0] INITIAL_KEY = 80'h0
) (
   input  logic              clk,
   input  logic              n_reset,
   present_decoder_if.slave  bus
);

   localparam int          NR_ROUNDS = 32;
   localparam logic [4:0]  LAST_RND  = 5'(NR_ROUNDS - 1);
   localparam logic [63:0] SBOX      = 64'hC56B90AD3EF84712;
   localparam logic [63:0] SBOX_INV  = 64'h5EF8C12DB463079A;

   typedef enum logic [1:0] {IDLE, KEYEXP, DEC, DONE} state_e;

   state_e      state_q, state_d;
   logic [63:0] word_q, word_d;
   logic [79:0] rkey_q, rkey_d;
   logic [79:0] klast_q, klast_d;
   logic [4:0]  rcnt_q, rcnt_d;
   logic        pend_q, pend_d;
   logic [79:0] kfwd, kinv;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      return SBOX[60 - 4*int'(x) +: 4];
   endfunction

   function automatic logic [3:0] sbox_inv(input logic [3:0] x);
      return SBOX_INV[60 - 4*int'(x) +: 4];
   endfunction

   function automatic logic [79:0] fwd_key(input logic [79:0] k, input logic [4:0] i);
      logic [79:0] r;
      r          = {k[18:0], k[79:19]};
      r[79:76]   = sbox(r[79:76]);
      r[19:15]   = r[19:15] ^ i;
      return r;
   endfunction

   function automatic logic [79:0] inv_key(input logic [79:0] k, input logic [4:0] i);
      logic [79:0] t;
      t          = k;
      t[19:15]   = t[19:15] ^ i;
      t[79:76]   = sbox_inv(t[79:76]);
      return {t[60:0], t[79:61]};
   endfunction

   // Undo the bit permutation first, then the nibble substitution.
   function automatic logic [63:0] inv_round(input logic [63:0] w);
      logic [63:0] p, s;
      for (int j = 0; j < 63; j++) p[j] = w[(16*j) % 63];
      p[63] = w[63];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = sbox_inv(p[4*n +: 4]);
      return s;
   endfunction

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      rkey_d  = rkey_q;
      klast_d = klast_q;
      rcnt_d  = rcnt_q;
      pend_d  = pend_q;
      kfwd    = fwd_key(rkey_q, rcnt_q);
      kinv    = inv_key(rkey_q, rcnt_q);
      case (state_q)
         KEYEXP: begin
            rkey_d = kfwd;
            rcnt_d = rcnt_q + 5'd1;
            if (rcnt_q == LAST_RND) begin
               klast_d = kfwd;
               if (pend_q) begin
                  word_d  = word_q ^ kfwd[79:16];
                  rcnt_d  = LAST_RND;
                  pend_d  = 1'b0;
                  state_d = DEC;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         IDLE, DONE: begin
            if (bus.pl[1]) begin
               rkey_d  = bus.in_text;
               rcnt_d  = 5'd1;
               state_d = KEYEXP;
               if (bus.pl[0]) begin
                  word_d = bus.in_text[63:0];
                  pend_d = 1'b1;
               end
            end else if (bus.pl[0]) begin
               word_d  = bus.in_text[63:0] ^ klast_q[79:16];
               rkey_d  = klast_q;
               rcnt_d  = LAST_RND;
               state_d = DEC;
            end
         end
         DEC: begin
            word_d = inv_round(word_q) ^ kinv[79:16];
            rkey_d = kinv;
            rcnt_d = rcnt_q - 5'd1;
            if (rcnt_q == 5'd1) state_d = DONE;
         end
         default: state_d = KEYEXP;
      endcase
   end

   // k_last is left alone by reset; the forced re-expansion rewrites it.
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state_q <= KEYEXP;
         word_q  <= '0;
         rkey_q  <= INITIAL_KEY;
         rcnt_q  <= 5'd1;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         rkey_q  <= rkey_d;
         klast_q <= klast_d;
         rcnt_q  <= rcnt_d;
         pend_q  <= pend_d;
      end
   end

   assign bus.ready     = (state_q == IDLE) || (state_q == DONE);
   assign bus.done      = (state_q == DONE);
   assign bus.plaintext = (state_q == DONE) ? word_q : 64'h0;

endmodule

// File: tb/tb_present_decoder.sv
// Directed and random bench for present_decoder, built around an independent PRESENT-80 reference model.
module tb_present_decoder;

   logic clk = 1'b0;
   logic n_reset = 1'b0;
   int   n_assert = 0;
   int   n_fail = 0;
   logic [63:0] sb_q[$];

   localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                      4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

   present_decoder_if bus();

   present_decoder #(.INITIAL_KEY(80'h0)) dut (
      .clk     (clk),
      .n_reset (n_reset),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] m_sinv(input logic [3:0] y);
      logic [3:0] r;
      r = 4'h0;
      for (int x = 0; x < 16; x++) if (SB[x] == y) r = 4'(x);
      return r;
   endfunction

   function automatic int m_pos(input int j);
      return (j == 63) ? 63 : (16 * j) % 63;
   endfunction

   function automatic logic [79:0] m_key_next(input logic [79:0] k, input int r);
      logic [79:0] t;
      t        = {k[18:0], k[79:19]};
      t[79:76] = SB[t[79:76]];
      t[19:15] = t[19:15] ^ 5'(r);
      return t;
   endfunction

   function automatic logic [63:0] m_enc(input logic [79:0] key, input logic [63:0] pt);
      logic [79:0] k;
      logic [63:0] s, o;
      k = key;
      s = pt;
      for (int r = 1; r <= 31; r++) begin
         s = s ^ k[79:16];
         for (int n = 0; n < 16; n++) s[4*n +: 4] = SB[s[4*n +: 4]];
         for (int j = 0; j < 64; j++) o[m_pos(j)] = s[j];
         s = o;
         k = m_key_next(k, r);
      end
      return s ^ k[79:16];
   endfunction

   function automatic logic [79:0] m_k32(input logic [79:0] key);
      logic [79:0] k;
      k = key;
      for (int r = 1; r <= 31; r++) k = m_key_next(k, r);
      return k;
   endfunction

   function automatic logic [63:0] m_dec(input logic [79:0] key, input logic [63:0] ct);
      logic [79:0] rk [1:32];
      logic [63:0] s, o;
      rk[1] = key;
      for (int r = 1; r <= 31; r++) rk[r+1] = m_key_next(rk[r], r);
      s = ct ^ rk[32][79:16];
      for (int r = 31; r >= 1; r--) begin
         for (int j = 0; j < 64; j++) o[j] = s[m_pos(j)];
         for (int n = 0; n < 16; n++) o[4*n +: 4] = m_sinv(o[4*n +: 4]);
         s = o ^ rk[r][79:16];
      end
      return s;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic wait_ready(input string tag, output int cyc);
      cyc = 0;
      while (!bus.ready && cyc < 200) begin
         step();
         cyc++;
      end
      if (!bus.ready) check({tag, "_ready_timeout"}, 80'(bus.ready), 80'd1);
   endtask

   task automatic run_op(input logic [1:0] p, input logic [79:0] txt, input logic [63:0] expv,
                         input int lat, input string tag, input bit pulse);
      int cyc;
      logic [63:0] e;
      wait_ready(tag, cyc);
      bus.pl      = p;
      bus.in_text = txt;
      sb_q.push_back(expv);
      step();
      bus.pl = 2'b00;
      check({tag, "_busy"}, 80'(bus.done), 80'd0);
      cyc = 0;
      while (!bus.done && cyc < 200) begin
         if (pulse) begin
            bus.pl      = 2'($urandom);
            bus.in_text = {$urandom, $urandom, 16'($urandom)};
         end
         step();
         cyc++;
      end
      bus.pl = 2'b00;
      check({tag, "_lat"}, 80'(cyc), 80'(lat));
      if (sb_q.size() == 0) begin
         check({tag, "_sb_empty"}, 80'(sb_q.size()), 80'd1);
      end else begin
         e = sb_q.pop_front();
         check({tag, "_pt"}, 80'(bus.plaintext), 80'(e));
      end
   endtask

   initial begin
      int cyc;
      logic [79:0] v;
      logic [63:0] pt;

      bus.pl      = 2'b00;
      bus.in_text = '0;
      n_reset     = 1'b0;
      repeat (3) step();
      check("rst_ready", 80'(bus.ready), 80'd0);
      check("rst_done", 80'(bus.done), 80'd0);
      check("rst_pt", 80'(bus.plaintext), 80'd0);
      n_reset = 1'b1;
      wait_ready("boot", cyc);
      check("boot_lat", 80'(cyc), 80'd31);
      check("klast_boot", dut.klast_q, m_k32(80'h0));

      run_op(2'b01, {16'h0, 64'h5579C1387B228445}, 64'h0, 31, "k0_zero", 1'b0);
      repeat (5) step();
      check("hold_done", 80'(bus.done), 80'd1);
      check("hold_ready", 80'(bus.ready), 80'd1);

      run_op(2'b11, {80{1'b1}}, m_dec({80{1'b1}}, {64{1'b1}}), 62, "ff_load", 1'b0);
      run_op(2'b01, {16'h0, 64'hE72C46C0F5945049}, 64'h0, 31, "ff_zero", 1'b0);
      run_op(2'b01, {16'h0, 64'h3333DCD3213210D2}, {64{1'b1}}, 31, "ff_ones", 1'b0);

      wait_ready("kload", cyc);
      bus.pl      = 2'b10;
      bus.in_text = 80'h0;
      step();
      bus.pl = 2'b00;
      check("kload_busy", 80'(bus.ready), 80'd0);
      wait_ready("kload", cyc);
      check("kload_lat", 80'(cyc), 80'd31);
      check("klast_k0", dut.klast_q, m_k32(80'h0));
      run_op(2'b01, {16'h0, 64'hA112FFC72F68417B}, {64{1'b1}}, 31, "k0_ones", 1'b0);

      v  = {$urandom, $urandom, 16'($urandom)};
      pt = {$urandom, $urandom};
      run_op(2'b11, v, m_dec(v, v[63:0]), 62, "pulse_keyexp", 1'b1);
      run_op(2'b01, {16'h0, m_enc(v, pt)}, pt, 31, "pulse_dec", 1'b1);
      check("klast_pulse", dut.klast_q, m_k32(v));

      for (int i = 0; i < 200; i++) begin
         if (i % 4 == 0) begin
            v = {$urandom, $urandom, 16'($urandom)};
            run_op(2'b11, v, m_dec(v, v[63:0]), 62, "rnd_key", 1'b0);
         end else begin
            pt = {$urandom, $urandom};
            run_op(2'b01, {16'h0, m_enc(v, pt)}, pt, 31, "rnd_blk", 1'b0);
         end
      end

      wait_ready("abort", cyc);
      bus.pl      = 2'b01;
      bus.in_text = {16'h0, 64'h5579C1387B228445};
      step();
      bus.pl = 2'b00;
      repeat (15) step();
      n_reset = 1'b0;
      step();
      check("abort_done", 80'(bus.done), 80'd0);
      check("abort_pt", 80'(bus.plaintext), 80'd0);
      check("abort_ready", 80'(bus.ready), 80'd0);
      n_reset = 1'b1;
      wait_ready("abort", cyc);
      check("abort_lat", 80'(cyc), 80'd31);
      check("klast_abort", dut.klast_q, m_k32(80'h0));
      run_op(2'b01, {16'h0, 64'h5579C1387B228445}, 64'h0, 31, "post_rst", 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
